// File: rtl/four_bit_seq_multiplier.sv
// ============================================================================
// Module   : four_bit_seq_multiplier
// Purpose  : Unsigned shift-add sequential multiplier, one partial product
//            per clock, fixed latency of WIDTH+1 cycles from acceptance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module four_bit_seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] p_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2*WIDTH-1:0] p_q,     p_d;
    logic               ready_q, ready_d;
    logic               done_q,  done_d;

    // Upper half plus carry after the conditional add; the carry only lives
    // for one cycle because the right shift immediately absorbs it.
    logic [WIDTH:0]     sum_w;
    logic [2*WIDTH-1:0] step_w;

    always_comb begin
        sum_w  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        step_w = {sum_w, acc_q[WIDTH-1:1]};

        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mcand_d = a_i;
                    acc_d   = {{WIDTH{1'b0}}, b_i};
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = step_w;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    p_d     = step_w;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe without any input-to-output path.
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign p_o     = p_q;

endmodule

`default_nettype wire

// File: tb/tb_four_bit_seq_multiplier.sv
// ============================================================================
// Module   : tb_four_bit_seq_multiplier
// Purpose  : Self-checking bench with an edge-count timing model for WIDTH=4
//            plus a WIDTH=8 latency/product check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_four_bit_seq_multiplier;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start;
    logic [W-1:0]   a, b;
    logic           ready, done;
    logic [2*W-1:0] p;

    logic           rst8, start8;
    logic [7:0]     a8, b8;
    logic           ready8, done8;
    logic [15:0]    p8;

    four_bit_seq_multiplier #(.WIDTH(W)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
        .ready_o(ready), .done_o(done), .p_o(p)
    );

    four_bit_seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst8), .start_i(start8), .a_i(a8), .b_i(b8),
        .ready_o(ready8), .done_o(done8), .p_o(p8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timing model in terms of edge numbers: an operation accepted at edge k
    // completes (done, new product) at edge k+W and is ready again from k+W+1.
    int             e          = 0;
    int             ready_edge = 0;
    int             done_edge  = -1;
    logic [2*W-1:0] pend       = '0;
    logic [2*W-1:0] m_p        = '0;
    logic           m_ready    = 1'b1;
    logic           m_done     = 1'b0;
    bit             valid      = 1'b0;

    always @(posedge clk) begin
        e++;
        if (rst) begin
            ready_edge = e;
            done_edge  = -1;
            m_p        = '0;
            valid      = 1'b1;
        end else if (m_ready && start) begin
            ready_edge = e + W + 1;
            done_edge  = e + W;
            pend       = a * b;
        end
        m_ready = (e >= ready_edge);
        m_done  = (e == done_edge);
        if (m_done) m_p = pend;
    end

    always @(negedge clk) begin
        if (valid) begin
            check("ready", ready, m_ready);
            check("done",  done,  m_done);
            check("p",     p,     m_p);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one op at a negedge while ready; returns cycles from acceptance
    // edge (inclusive) to the cycle where done is seen, and the product.
    task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                      output int lat, output logic [2*W-1:0] pr);
        a = aa; b = bb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("op_timeout", 0, 1);
        pr = p;
    endtask

    initial begin
        int             lat;
        logic [2*W-1:0] pr;
        int             idx, ndone, c, last;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        cyc(2);
        check("rst_ready", ready, 1);
        check("rst_done",  done,  0);
        check("rst_p",     p,     0);
        rst = 1'b0; rst8 = 1'b0;

        // 15*15 basic
        op(4'd15, 4'd15, lat, pr);
        check("basic_lat", lat, 5);
        check("basic_p", pr, 225);
        check("model_basic_p", m_p, 225);
        cyc(3);
        check("basic_hold", p, 225);

        // Busy-ignore: new operands and start during CALC do nothing
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(negedge clk);
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!done && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("busy_p", p, 15);
        check("model_busy_p", m_p, 15);
        cyc(8);
        check("busy_after_p", p, 15);

        // Reset in the second CALC cycle aborts the op
        a = 4'd7; b = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_p", p, 0);
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        cyc(6);
        op(4'd2, 4'd3, lat, pr);
        check("post_rst_p", pr, 6);
        cyc(1);

        // Zero operand still takes full latency; then hold 1*13
        op(4'd0, 4'd13, lat, pr);
        check("zero_lat", lat, 5);
        check("zero_p", pr, 0);
        cyc(1);
        op(4'd1, 4'd13, lat, pr);
        check("one_p", pr, 13);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_p", p, 13);
        end

        // Exhaustive back-to-back with start held high
        idx = 0; ndone = 0; c = 0; last = -1;
        start = 1'b1;
        while (ndone < 256 && c < 256 * 6 + 40) begin
            if (m_ready) begin
                if (idx < 256) begin
                    a = idx[7:4]; b = idx[3:0];
                    idx++;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            c++;
            if (done) begin
                if (last >= 0) check("period", c - last, 6);
                last = c;
                ndone++;
            end
        end
        start = 1'b0;
        check("exh_count", ndone, 256);
        cyc(8);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            start = ($urandom % 3 == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            rst   = ($urandom % 50 == 0);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        cyc(8);

        // WIDTH=8 instance
        a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("w8_lat", lat, 9);
        check("w8_p", p8, 65025);
        @(negedge clk);
        check("w8_done_pulse", done8, 0);
        check("w8_ready", ready8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
